// File: rtl/mips_regfile.sv
// 32x32 MIPS register file: registered rs/rt reads with a request/valid handshake, $zero hardwired.
// Optional write-to-read forwarding at a same-edge collision when REGFILE_BYPASS_EN is defined.
module mips_regfile #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    output logic [DATA_W-1:0] rs_data,
    output logic [DATA_W-1:0] rt_data,
    output logic              rd_valid,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_busy,
    output logic [7:0]        rd_count
);

    localparam int NREGS = 1 << ADDR_W;

    // Handshake: rd_req sampled at an edge loads rs_data/rt_data at that same
    // edge and rd_valid is high for the following cycle; no backpressure.
    typedef enum logic {
        IDLE  = 1'b0,
        VALID = 1'b1
    } rd_state_t;

    rd_state_t         state;
    logic [DATA_W-1:0] regs [NREGS];
    logic [DATA_W-1:0] rs_next;
    logic [DATA_W-1:0] rt_next;
    logic              wr_live;

    assign wr_live = wr_en && (wr_addr != '0);

    always_comb begin
        rs_next = (rs_addr == '0) ? '0 : regs[rs_addr];
        rt_next = (rt_addr == '0) ? '0 : regs[rt_addr];
`ifdef REGFILE_BYPASS_EN
        if (wr_live && (wr_addr == rs_addr)) rs_next = wr_data;
        if (wr_live && (wr_addr == rt_addr)) rt_next = wr_data;
`endif
    end

    // regs[0] is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (wr_live) begin
            regs[wr_addr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_busy <= 1'b0;
        end else begin
            wr_busy <= wr_en;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            rd_valid <= 1'b0;
            rs_data  <= '0;
            rt_data  <= '0;
            rd_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (rd_req) begin
                        state    <= VALID;
                        rd_valid <= 1'b1;
                    end
                end
                VALID: begin
                    if (!rd_req) begin
                        state    <= IDLE;
                        rd_valid <= 1'b0;
                    end
                end
                default: begin
                    state    <= IDLE;
                    rd_valid <= 1'b0;
                end
            endcase
            if (rd_req) begin
                rs_data  <= rs_next;
                rt_data  <= rt_next;
                rd_count <= rd_count + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_mips_regfile.sv
// Self-checking bench for mips_regfile: reference register model, expected-read queue, summary line.
module tb_mips_regfile;

    logic        clk;
    logic        reset_n;
    logic        rd_req;
    logic [4:0]  rs_addr;
    logic [4:0]  rt_addr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic        rd_valid;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        wr_busy;
    logic [7:0]  rd_count;

    mips_regfile #(.DATA_W(32), .ADDR_W(5)) dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .rd_req   (rd_req),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rs_data  (rs_data),
        .rt_data  (rt_data),
        .rd_valid (rd_valid),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_busy  (wr_busy),
        .rd_count (rd_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] model [32];
    logic [63:0] exp_q [$];
    logic [63:0] held;
    logic [7:0]  exp_cnt;
    int          n_checks;
    int          n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        rd_req  = 1'b1;
        rs_addr = 5'd9;
        rt_addr = 5'd9;
        wr_en   = 1'b1;
        wr_addr = 5'd9;
        wr_data = 32'hDEADBEEF;
        for (int i = 0; i < 32; i++) model[i] = '0;
        exp_cnt = '0;
        held    = '0;
        exp_q.delete();
        @(posedge clk);
        #1;
        check("rst_rd_valid", {63'd0, rd_valid}, 64'd0);
        check("rst_wr_busy", {63'd0, wr_busy}, 64'd0);
        check("rst_data", {rs_data, rt_data}, 64'd0);
        check("rst_rd_count", {56'd0, rd_count}, 64'd0);
        reset_n = 1'b1;
        rd_req  = 1'b0;
        wr_en   = 1'b0;
    endtask

    // One clock: drive inputs, push the expected read result, then compare after the edge.
    task automatic step(input logic rq, input logic [4:0] ra, input logic [4:0] rb,
                        input logic we, input logic [4:0] wa, input logic [31:0] wd);
        logic [31:0] e_rs;
        logic [31:0] e_rt;
        logic [63:0] e;
        rd_req  = rq;
        rs_addr = ra;
        rt_addr = rb;
        wr_en   = we;
        wr_addr = wa;
        wr_data = wd;
        if (rq) begin
            e_rs = (ra == 5'd0) ? 32'd0 : model[ra];
            e_rt = (rb == 5'd0) ? 32'd0 : model[rb];
`ifdef REGFILE_BYPASS_EN
            if (we && wa != 5'd0 && wa == ra) e_rs = wd;
            if (we && wa != 5'd0 && wa == rb) e_rt = wd;
`endif
            exp_q.push_back({e_rs, e_rt});
            exp_cnt = exp_cnt + 8'd1;
        end
        if (we && wa != 5'd0) model[wa] = wd;
        @(posedge clk);
        #1;
        check("rd_valid", {63'd0, rd_valid}, {63'd0, rq});
        check("wr_busy", {63'd0, wr_busy}, {63'd0, we});
        check("rd_count", {56'd0, rd_count}, {56'd0, exp_cnt});
        if (rq) begin
            if (exp_q.size() == 0) begin
                check("queue_empty", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                held = e;
                check("rd_data", {rs_data, rt_data}, e);
            end
        end else begin
            check("hold_data", {rs_data, rt_data}, held);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        rd_req   = 1'b0;
        rs_addr  = '0;
        rt_addr  = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        exp_cnt  = '0;
        held     = '0;
        for (int i = 0; i < 32; i++) model[i] = '0;

        do_reset();
        for (int k = 0; k < 32; k++) step(1'b1, 5'(k), 5'(k), 1'b0, 5'd0, 32'd0);
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);

        step(1'b0, 5'd0, 5'd0, 1'b1, 5'd5, 32'h1C71C71C);
        step(1'b1, 5'd5, 5'd5, 1'b0, 5'd0, 32'd0);

        step(1'b0, 5'd0, 5'd0, 1'b1, 5'd0, 32'hFFFFFFFF);
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);
        step(1'b1, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);

        step(1'b0, 5'd0, 5'd0, 1'b1, 5'd3, 32'h00000001);
        step(1'b1, 5'd3, 5'd5, 1'b1, 5'd3, 32'h80000000);
        step(1'b1, 5'd5, 5'd3, 1'b1, 5'd5, 32'h00000007);
        step(1'b1, 5'd3, 5'd5, 1'b0, 5'd0, 32'd0);

        do_reset();
        for (int i = 0; i < 256; i++)
            step(1'b1, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom);
        check("count_wrap", {56'd0, rd_count}, 64'd0);

        for (int i = 0; i < 200; i++)
            step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                 1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);

        step(1'b1, 5'd7, 5'd7, 1'b1, 5'd7, 32'h00000001);
        do_reset();
        step(1'b1, 5'd7, 5'd7, 1'b0, 5'd0, 32'd0);
        step(1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
